// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit ASCII expressions using '+' and '*' ('*' binds tighter), terminated by '='.
// One character is accepted per cycle with no stalls. Results wrap modulo 2^W, with a sticky overflow flag.
module expr_eval #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic [W-1:0] value,
    output logic         valid,
    output logic [W-1:0] result,
    output logic         done,
    output logic         err,
    output logic         ovf
);

    typedef enum logic [1:0] {ST_START, ST_NUM, ST_OP, ST_ERROR} state_t;

    state_t       r_state;
    logic [W-1:0] r_sum;
    logic [W-1:0] r_prod;
    logic [W-1:0] r_value;
    logic [W-1:0] r_result;
    logic         r_valid;
    logic         r_done;
    logic         r_err;
    logic         r_ovf;

    logic         w_is_dig;
    logic         w_is_plus;
    logic         w_is_mul;
    logic         w_is_eq;
    logic [3:0]   w_dig;
    logic [W-1:0] w_dig_w;
    logic [W+3:0] w_mul_full;
    logic [W:0]   w_add_full;
    logic [W-1:0] w_mul;
    logic [W-1:0] w_add;
    logic         w_mul_ovf;

    assign w_is_dig   = (in >= 8'h30) && (in <= 8'h39);
    assign w_is_plus  = (in == 8'h2B);
    assign w_is_mul   = (in == 8'h2A);
    assign w_is_eq    = (in == 8'h3D);
    assign w_dig      = in[3:0];
    assign w_dig_w    = {{(W-4){1'b0}}, w_dig};

    // Full-precision results; the bits above W flag overflow.
    assign w_mul_full = {4'b0000, r_prod} * {{W{1'b0}}, w_dig};
    assign w_add_full = {1'b0, r_sum} + {1'b0, r_prod};
    assign w_mul      = w_mul_full[W-1:0];
    assign w_add      = w_add_full[W-1:0];
    assign w_mul_ovf  = |w_mul_full[W+3:W];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= ST_START;
            r_sum    <= '0;
            r_prod   <= {{(W-1){1'b0}}, 1'b1};
            r_value  <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    ST_START: begin
                        // The overflow flag of the previous expression is held until the next one begins.
                        r_ovf <= 1'b0;
                        if (w_is_dig) begin
                            r_prod  <= w_dig_w;
                            r_value <= w_dig_w;
                            r_valid <= 1'b1;
                            r_state <= ST_OP;
                        end else begin
                            r_err   <= 1'b1;
                            r_value <= '0;
                            r_valid <= 1'b0;
                            r_state <= ST_ERROR;
                        end
                    end
                    ST_NUM: begin
                        if (w_is_dig) begin
                            r_prod  <= w_mul;
                            r_value <= r_sum + w_mul;
                            r_valid <= 1'b1;
                            if (w_mul_ovf) r_ovf <= 1'b1;
                            r_state <= ST_OP;
                        end else begin
                            r_err   <= 1'b1;
                            r_value <= '0;
                            r_valid <= 1'b0;
                            r_state <= ST_ERROR;
                        end
                    end
                    ST_OP: begin
                        if (w_is_plus) begin
                            r_sum   <= w_add;
                            r_prod  <= {{(W-1){1'b0}}, 1'b1};
                            r_valid <= 1'b0;
                            if (w_add_full[W]) r_ovf <= 1'b1;
                            r_state <= ST_NUM;
                        end else if (w_is_mul) begin
                            r_valid <= 1'b0;
                            r_state <= ST_NUM;
                        end else if (w_is_eq) begin
                            r_result <= w_add;
                            r_done   <= 1'b1;
                            if (w_add_full[W]) r_ovf <= 1'b1;
                            r_sum    <= '0;
                            r_prod   <= {{(W-1){1'b0}}, 1'b1};
                            r_value  <= '0;
                            r_valid  <= 1'b0;
                            r_state  <= ST_START;
                        end else begin
                            r_err   <= 1'b1;
                            r_value <= '0;
                            r_valid <= 1'b0;
                            r_state <= ST_ERROR;
                        end
                    end
                    ST_ERROR: begin
                        r_state <= ST_ERROR;
                    end
                    default: begin
                        r_state <= ST_ERROR;
                    end
                endcase
            end
        end
    end

    assign value  = r_value;
    assign valid  = r_valid;
    assign result = r_result;
    assign done   = r_done;
    assign err    = r_err;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_expr_eval.sv
// Drives identical character streams into a 16-bit and an 8-bit evaluator; a string-based reference
// model predicts every cycle's outputs into queues, and a negedge monitor drains and compares them.
module tb_expr_eval;

    typedef struct packed {
        logic [15:0] value;
        logic [15:0] result;
        logic        valid;
        logic        done;
        logic        err;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;

    logic [15:0] v16, r16;
    logic        va16, d16, e16, o16;
    logic [7:0]  v8, r8;
    logic        va8, d8, e8, o8;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q16[$];
    exp_t q8[$];

    // Reference model state: characters consumed since the last restart
    byte         s[$];
    bit          m_err  = 1'b0;
    bit          m_done = 1'b0;
    logic [15:0] m_res16 = 16'h0;
    logic [15:0] m_res8  = 16'h0;
    bit          m_ovh16 = 1'b0;
    bit          m_ovh8  = 1'b0;

    expr_eval #(.W(16)) u16 (
        .clk(clk), .clr(clr), .in(din), .in_valid(din_vld),
        .value(v16), .valid(va16), .result(r16), .done(d16), .err(e16), .ovf(o16)
    );

    expr_eval #(.W(8)) u8 (
        .clk(clk), .clr(clr), .in(din), .in_valid(din_vld),
        .value(v8), .valid(va8), .result(r8), .done(d8), .err(e8), .ovf(o8)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_dig(byte c);
        return (c >= 8'sh30) && (c <= 8'sh39);
    endfunction

    // Evaluates the string with '*' before '+' in full precision, wrapping to w bits.
    // Without fin, the value is the one after the last digit and the final addition is not counted.
    function automatic void ev(input byte q[$], input int w, input bit fin,
                               output logic [15:0] val, output bit ov);
        longint mask, sum, prod, t, last;
        mask = (64'd1 << w) - 1;
        sum  = 0;
        prod = 1;
        last = 0;
        ov   = 1'b0;
        foreach (q[i]) begin
            if (is_dig(q[i])) begin
                t = prod * longint'(q[i] - 8'sh30);
                if (t > mask) ov = 1'b1;
                prod = t & mask;
                last = (sum + prod) & mask;
            end else if (q[i] == 8'sh2B) begin
                t = sum + prod;
                if (t > mask) ov = 1'b1;
                sum  = t & mask;
                prod = 1;
            end
        end
        if (fin) begin
            t = sum + prod;
            if (t > mask) ov = 1'b1;
            last = t & mask;
        end
        val = last[15:0];
    endfunction

    function automatic exp_t mk(int w, logic [15:0] res, bit ovh);
        exp_t        e;
        logic [15:0] v;
        bit          ov;
        ev(s, w, 1'b0, v, ov);
        e.err    = m_err;
        e.done   = m_done;
        e.result = res;
        e.valid  = !m_err && (s.size() > 0) && is_dig(s[s.size()-1]);
        e.value  = (m_err || s.size() == 0) ? 16'h0 : v;
        e.ovf    = (s.size() == 0) ? (m_err ? 1'b0 : ovh) : ov;
        return e;
    endfunction

    task automatic model_step(byte c, bit v);
        bit          exp_dig;
        logic [15:0] val;
        bit          ov;
        m_done = 1'b0;
        if (!v || m_err) return;
        exp_dig = (s.size() == 0) || !is_dig(s[s.size()-1]);
        if (exp_dig) begin
            if (is_dig(c)) s.push_back(c);
            else m_err = 1'b1;
        end else if (c == 8'sh2B || c == 8'sh2A) begin
            s.push_back(c);
        end else if (c == 8'sh3D) begin
            ev(s, 16, 1'b1, val, ov);
            m_res16 = val;
            m_ovh16 = ov;
            ev(s, 8, 1'b1, val, ov);
            m_res8  = val;
            m_ovh8  = ov;
            m_done  = 1'b1;
            s.delete();
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic cmp(string nm, logic [15:0] a, logic [15:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q16.size() > 0) begin
            e = q16.pop_front();
            cmp("w16.value",  v16,         e.value);
            cmp("w16.result", r16,         e.result);
            cmp("w16.valid",  16'(va16),   16'(e.valid));
            cmp("w16.done",   16'(d16),    16'(e.done));
            cmp("w16.err",    16'(e16),    16'(e.err));
            cmp("w16.ovf",    16'(o16),    16'(e.ovf));
        end
        if (q8.size() > 0) begin
            e = q8.pop_front();
            cmp("w8.value",   16'(v8),     e.value);
            cmp("w8.result",  16'(r8),     e.result);
            cmp("w8.valid",   16'(va8),    16'(e.valid));
            cmp("w8.done",    16'(d8),     16'(e.done));
            cmp("w8.err",     16'(e8),     16'(e.err));
            cmp("w8.ovf",     16'(o8),     16'(e.ovf));
        end
    end

    task automatic send(byte c, bit v);
        @(negedge clk);
        din     = c;
        din_vld = v;
        @(posedge clk);
        model_step(c, v);
        q16.push_back(mk(16, m_res16, m_ovh16));
        q8.push_back(mk(8, m_res8, m_ovh8));
        #1 din_vld = 1'b0;
    endtask

    task automatic send_str(string str, bit alt);
        for (int i = 0; i < str.len(); i++) begin
            send(byte'(str[i]), 1'b1);
            if (alt) send(byte'($urandom_range(255)), 1'b0);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((q16.size() > 0 || q8.size() > 0) && g < 20) begin
            @(negedge clk);
            g++;
        end
        #1;
        if (q16.size() > 0 || q8.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q16.size());
            q16.delete();
            q8.delete();
        end
    endtask

    // Asserts clr between clock edges; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        drain();
        clr = 1'b1;
        #1;
        cmp("rst.w16.value",  v16, 16'h0);
        cmp("rst.w16.result", r16, 16'h0);
        cmp("rst.w16.flags",  16'({va16, d16, e16, o16}), 16'h0);
        cmp("rst.w8.value",   16'(v8), 16'h0);
        cmp("rst.w8.result",  16'(r8), 16'h0);
        cmp("rst.w8.flags",   16'({va8, d8, e8, o8}), 16'h0);
        s.delete();
        m_err   = 1'b0;
        m_done  = 1'b0;
        m_res16 = 16'h0;
        m_res8  = 16'h0;
        m_ovh16 = 1'b0;
        m_ovh8  = 1'b0;
        din     = 8'h2B;
        din_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr     = 1'b0;
        din_vld = 1'b0;
    endtask

    initial begin
        byte c;
        bit  exp_dig;
        int  r;
        do_reset();

        send_str("3+4*5=", 1'b0);
        send_str("2*3*4+1=", 1'b0);
        send_str("9=", 1'b0);
        send_str("9*9*9=", 1'b0);
        send_str("1=", 1'b0);
        send_str("9*9*9*9*9*9+8*9*9*9*9*9=", 1'b0);
        send_str("5=", 1'b0);

        do_reset();
        send_str("+35=", 1'b0);
        do_reset();
        send_str("34=", 1'b0);
        do_reset();
        send_str("3+=", 1'b0);
        do_reset();
        send_str("3+4", 1'b0);
        do_reset();
        send_str("6=", 1'b0);
        send_str("3+4=", 1'b1);

        for (int i = 0; i < 600; i++) begin
            if (m_err && $urandom_range(3) == 0) do_reset();
            exp_dig = (s.size() == 0) || !is_dig(s[s.size()-1]);
            r = int'($urandom_range(99));
            if (r < 3) begin
                c = byte'($urandom_range(255));
            end else if (exp_dig ? (r < 96) : (r < 8)) begin
                c = byte'(48 + $urandom_range(9));
            end else begin
                case ($urandom_range(5))
                    0, 1, 2: c = 8'sh2A;
                    3, 4:    c = 8'sh2B;
                    default: c = 8'sh3D;
                endcase
            end
            send(c, $urandom_range(4) != 0);
        end

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
